// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types for the CAN receive message buffer
// Contents: rx_msg_t (stored frame), rd_state_e (host read sequencer), DLC field bounds.
package can_pkg;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] dlc;
        logic [31:0] dw1;
        logic [31:0] dw2;
    } rx_msg_t;

    typedef enum logic [1:0] {
        RD_ID  = 2'd0,
        RD_DLC = 2'd1,
        RD_DW1 = 2'd2,
        RD_DW2 = 2'd3
    } rd_state_e;

    localparam int DLC_MSB = 31;
    localparam int DLC_LSB = 28;

endpackage

// File: rtl/can_rx_fifo_mem.sv
// rtl/can_rx_fifo_mem.sv - DEPTH x 128-bit message storage, one write port, combinational read
// Ports: i_clk; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_addr -> o_rd_data read port.
// Storage is deliberately not reset.
module can_rx_fifo_mem
    import can_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  rx_msg_t       i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output rx_msg_t       o_rd_data
);

    rx_msg_t mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/can_rx_fifo.sv
// rtl/can_rx_fifo.sv - CAN receive message FIFO with host word-read sequencer
// Optional feature macro: CAN_RX_FIFO_WATERMARK_EN (adds WMARK parameter and o_rx_wmark).
// Ports:
//   i_sys_clk, i_reset_n (async active-low), i_fifo_flush (sync clear)
//   i_rx_valid, i_afr_pass, i_rx_id, i_rx_dlc, i_rx_dw1, i_rx_dw2 : frame capture
//   i_rd_req -> o_rd_data, o_rd_valid                           : host word reads
//   o_rx_empty, o_rx_full, o_rx_cnt, o_rx_ok, o_rx_ovr, i_ovr_clr : status
module can_rx_fifo
    import can_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
`ifdef CAN_RX_FIFO_WATERMARK_EN
    ,
    parameter int WMARK = 8
`endif
) (
    input  logic        i_sys_clk,
    input  logic        i_reset_n,
    input  logic        i_fifo_flush,
    input  logic        i_rx_valid,
    input  logic        i_afr_pass,
    input  logic [31:0] i_rx_id,
    input  logic [31:0] i_rx_dlc,
    input  logic [31:0] i_rx_dw1,
    input  logic [31:0] i_rx_dw2,
    input  logic        i_rd_req,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_rx_empty,
    output logic        o_rx_full,
    output logic [AW:0] o_rx_cnt,
    output logic        o_rx_ok,
    output logic        o_rx_ovr,
`ifdef CAN_RX_FIFO_WATERMARK_EN
    output logic        o_rx_wmark,
`endif
    input  logic        i_ovr_clr
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    rd_state_e     state_q, state_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          rx_ok_q, rx_ok_d;
    logic          ovr_q, ovr_d;
`ifdef CAN_RX_FIFO_WATERMARK_EN
    localparam logic [AW:0] WMARK_C = (AW+1)'(WMARK);
    logic          wmark_q, wmark_d;
`endif

    logic          wr_req;
    logic          push;
    logic          pop;
    logic          overflow;
    rx_msg_t       wr_msg;
    rx_msg_t       rd_msg;
    logic          unused_dlc_low;

    assign wr_msg = '{id: i_rx_id, dlc: i_rx_dlc, dw1: i_rx_dw1, dw2: i_rx_dw2};

    // Only the DLC nibble is ever presented to the host.
    assign unused_dlc_low = ^rd_msg.dlc[DLC_LSB-1:0];

    can_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (i_sys_clk),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (wr_msg),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (rd_msg)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rx_ok_d    = 1'b0;
        ovr_d      = ovr_q;
        pop        = 1'b0;
        push       = 1'b0;
        overflow   = 1'b0;
        wr_req     = i_rx_valid & i_afr_pass;

        // Host read sequencer: one word per request; an empty FIFO answers 0
        // without moving the sequencer.
        if (i_rd_req) begin
            rd_valid_d = 1'b1;
            if (empty_q) begin
                rd_data_d = '0;
            end else begin
                unique case (state_q)
                    RD_ID: begin
                        rd_data_d = rd_msg.id;
                        state_d   = RD_DLC;
                    end
                    RD_DLC: begin
                        rd_data_d = {rd_msg.dlc[DLC_MSB:DLC_LSB], {DLC_LSB{1'b0}}};
                        state_d   = RD_DW1;
                    end
                    RD_DW1: begin
                        rd_data_d = rd_msg.dw1;
                        state_d   = RD_DW2;
                    end
                    RD_DW2: begin
                        rd_data_d = rd_msg.dw2;
                        state_d   = RD_ID;
                        pop       = 1'b1;
                    end
                    default: state_d = RD_ID;
                endcase
            end
        end

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        // When full, wr_ptr equals rd_ptr: the popped entry is read combinationally
        // before the new frame lands on the clock edge.
        push     = wr_req & (~full_q | pop);
        overflow = wr_req & full_q & ~pop;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        rx_ok_d = push;

        // A fresh overflow wins over a same-cycle clear.
        if (i_ovr_clr) ovr_d = 1'b0;
        if (overflow)  ovr_d = 1'b1;

        if (i_fifo_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            state_d    = RD_ID;
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
            rx_ok_d    = 1'b0;
            ovr_d      = 1'b0;
            push       = 1'b0;
            pop        = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

`ifdef CAN_RX_FIFO_WATERMARK_EN
    always_comb begin
        wmark_d = (count_d >= WMARK_C);
        if (i_fifo_flush) wmark_d = 1'b0;
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) wmark_q <= 1'b0;
        else            wmark_q <= wmark_d;
    end

    assign o_rx_wmark = wmark_q;
`endif

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= RD_ID;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rx_ok_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rx_ok_q    <= rx_ok_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_rx_empty = empty_q;
    assign o_rx_full  = full_q;
    assign o_rx_cnt   = count_q;
    assign o_rx_ok    = rx_ok_q;
    assign o_rx_ovr   = ovr_q;

endmodule

// File: doc/can_rx_fifo.md
Name: can_rx_fifo

Overview:
- Receive message buffer directly downstream of the acceptance filter.
- Captures each fully received CAN frame (ID, DLC, two data words) when the filter asserts pass.
- Holds frames in a circular buffer and lets the host read them one 32-bit word at a time through a small read sequencer.
- Generates empty/full/overflow/receive-OK status for the interrupt block.

Parameters:
DEPTH, 16, number of message entries (power of two, 2..64)
AW, 4, pointer width = log2(DEPTH)

Ports:
i_sys_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_fifo_flush  in  1  synchronous clear of pointers and flags (SRR soft reset)
i_rx_valid  in  1  one-cycle strobe: frame complete, message fields valid
i_afr_pass  in  1  acceptance filter result for the frame on the bus this cycle
i_rx_id  in  32  ID word (same word the filter compares)
i_rx_dlc  in  32  DLC word, bits [31:28] meaningful
i_rx_dw1  in  32  data bytes 0-3
i_rx_dw2  in  32  data bytes 4-7
i_rd_req  in  1  host word-read request
o_rd_data  out  32  read word, valid when o_rd_valid=1
o_rd_valid  out  1  one-cycle read-data strobe
o_rx_empty  out  1  no stored message
o_rx_full  out  1  DEPTH messages stored
o_rx_cnt  out  AW+1  stored message count
o_rx_ok  out  1  one-cycle pulse per accepted message
o_rx_ovr  out  1  sticky overflow flag
i_ovr_clr  in  1  clears o_rx_ovr

Behaviour:
- Reset (async, i_reset_n=0): pointers=0, count=0, read FSM=RD_ID, o_rd_data=0, o_rd_valid=0, o_rx_empty=1, o_rx_full=0, o_rx_ok=0, o_rx_ovr=0. Storage contents are not reset.
- Write acceptance: write = i_rx_valid & i_afr_pass.
  - If not full, or a pop occurs in the same cycle: the four words are stored at wr_ptr, wr_ptr increments modulo DEPTH, and o_rx_ok pulses the next cycle.
  - If full with no pop: the frame is dropped, o_rx_ovr is set, and o_rx_ok stays 0.
- i_rx_valid with i_afr_pass=0: ignored, with no flag change.
- Read FSM states RD_ID -> RD_DLC -> RD_DW1 -> RD_DW2 -> RD_ID. Each i_rd_req advances one state.
  - o_rd_data holds the current entry word for that state (DLC word with [27:0] forced 0), registered.
  - o_rd_valid rises one cycle after i_rd_req.
  - Leaving RD_DW2 pops the entry: rd_ptr increments modulo DEPTH.
- i_rd_req while empty: o_rd_data=0, o_rd_valid=1, FSM and pointers unchanged.
- A write of a new entry never disturbs an entry being read mid-sequence.
- Count: count = count + push - pop, in the range 0..DEPTH. Flags are registered from the next count.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- i_fifo_flush: same values as reset, except that o_rx_ovr is also cleared. Flush takes priority over a same-cycle write or read.
- i_ovr_clr and a new overflow in the same cycle: the flag stays set.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.

Optional Feature:
CAN_RX_FIFO_WATERMARK_EN
- When defined:
  - Adds parameter WMARK (default 8) and output o_rx_wmark (1 bit).
  - o_rx_wmark is registered and equals 1 when count >= WMARK.
  - Reset value of o_rx_wmark is 0; flush clears it.
- When not defined: no port and no comparator; all other behaviour is identical.

Decomposition:
- Shared package can_pkg holds:
  - typedef struct rx_msg_t {id, dlc, dw1, dw2}, each 32 bits
  - enum rd_state_e {RD_ID, RD_DLC, RD_DW1, RD_DW2}
  - localparam DLC_MSB=31, DLC_LSB=28
- One sub-module, can_rx_fifo_mem: DEPTH x 128-bit register array with a write port and a combinational read port, with no reset on storage.
- The pointers, counter, flags and read FSM stay in the top module.

Test Plan:
- Reset, then one write (id=32'h1234_5678, dlc=32'h8000_0000, dw1=32'hDEAD_BEEF, dw2=32'hCAFE_F00D, pass=1) -> o_rx_ok pulse, o_rx_cnt=1, o_rx_empty=0. Four i_rd_req -> o_rd_data sequence 12345678, 80000000, DEADBEEF, CAFEF00D. After the fourth read, o_rx_cnt=0 and o_rx_empty=1.
- i_rx_valid with pass=0 -> o_rx_cnt stays 0, no o_rx_ok pulse.
- Write 17 frames with DEPTH=16 -> o_rx_full=1 after the 16th, o_rx_ovr=1 after the 17th. Reading all entries returns frames 1..16 in order. i_ovr_clr -> o_rx_ovr=0.
- Full FIFO, then a write and the DW2 read (pop) in the same cycle -> frame accepted, o_rx_cnt stays 16, o_rx_ovr stays 0.
- i_rd_req on an empty FIFO -> o_rd_valid=1, o_rd_data=0, next i_rd_req still returns ID state data.
- 3 frames stored, read halted at RD_DW1, then assert i_fifo_flush -> count=0, empty=1, FSM back at RD_ID. With CAN_RX_FIFO_WATERMARK_EN defined and WMARK=2, o_rx_wmark=1 before the flush and 0 after.
